rgb_value_overlay: RTL and testbench
====================================

Name: rgb_value_overlay

Overview:
- Downstream consumer of the per-digit glyph ROMs on the Value_RGB display path.
- Overlays the R, G and B values of the probed pixel as three lines of three 16x16 decimal digits onto the outgoing video stream.
- Registers the nine glyph-row addresses fed to the ROMs and takes back the nine combinational 16-bit row patterns.
- Picks the glyph bit for the current pixel, with hundreds/tens leading-zero blanking and frame-synchronous value update.

Parameters:
- X0, 16: left pixel column of the text block.
- Y0, 16: top pixel row of the R line.
- LINE_PITCH, 20: vertical distance between line tops (R, G, B); must be >= 16.
- FG_COLOR, 24'hFFFFFF: colour of set glyph pixels.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- hcnt  in  11  current pixel column from the timing generator.
- vcnt  in  11  current pixel row from the timing generator.
- de_in  in  1  active video.
- hsync_in  in  1  horizontal sync, passed through.
- vsync_in  in  1  vertical sync, active-high; its rising edge marks the frame boundary.
- rgb_in  in  24  background pixel, {R,G,B}.
- val_r, val_g, val_b  in  8 each  new value set to display.
- val_valid  in  1  one-cycle strobe; captures val_r, val_g and val_b.
- addr_R_h, addr_R_d, addr_R_u, addr_G_h, addr_G_d, addr_G_u, addr_B_h, addr_B_d, addr_B_u  out  4 each  glyph row address to the ROMs.
- Char_R_h, Char_R_d, Char_R_u, Char_G_h, Char_G_d, Char_G_u, Char_B_h, Char_B_d, Char_B_u  in  16 each  glyph row, declared [0:15]; bit 0 is the leftmost pixel.
- rgb_out  out  24  composited pixel.
- de_out, hsync_out, vsync_out  out  1 each  syncs, delayed to match rgb_out.

Behaviour:
- Reset: every output and internal register goes to 0, including the address ports, rgb_out, the delayed syncs, and the pending and shown values. Reset mid-frame clears the pipeline immediately, so the first two cycles after release output 0.
- Value capture: when val_valid=1, val_r, val_g and val_b are written into pending registers. The last strobe before a frame boundary wins.
- Frame update: the shown registers take the pending registers on the cycle after the vsync_in rising edge is detected (vsync_in=1 and the registered previous vsync=0).
  - A val_valid on the same cycle as that update goes to pending only and is shown from the next frame.
  - There is never a mid-frame value change.
- Blanking flags, computed from the shown values:
  - hundreds digit blanked when value < 100;
  - tens digit blanked when value < 10;
  - units digit never blanked.
- Stage 1 (registered, cycle N+1):
  - Line k (0=R, 1=G, 2=B) is hit when vcnt is in [Y0+k*LINE_PITCH, Y0+k*LINE_PITCH+15].
  - The three addresses of a hit line are vcnt-(Y0+k*LINE_PITCH), low 4 bits. The addresses of lines not hit are 0.
  - Slot j (0=h, 1=d, 2=u) is hit when hcnt is in [X0+16j, X0+16j+15]; column index = hcnt-(X0+16j), 4 bits.
  - Registered in stage 1: line hit, slot hit, column index, blank flag of the hit slot, rgb_in, de_in, hsync_in, vsync_in.
- Stage 2 (registered, cycle N+2):
  - The bit is taken from the ROM row of the hit line/slot at the column index.
  - rgb_out = FG_COLOR when de=1, line and slot are hit, the slot is not blanked and the bit is 1.
  - Otherwise rgb_out = the delayed rgb_in when de=1, and 0 when de=0.
  - The syncs are delayed one more stage.
- Latency: exactly 2 cycles from hcnt/vcnt/rgb_in/syncs to rgb_out and the synced outputs; constant, no stalls.
- The ROM is combinational. It is read between stages 1 and 2 using the registered addresses, so the row data is aligned with stage 1.
- Width rules:
  - All coordinate compares are unsigned, 11-bit.
  - Parameter sums are evaluated at 11 bits; the bench keeps the text block inside the 2048 range (no wrap).
  - hcnt < X0 or vcnt < Y0 is a miss, not a wrap.
- Lines do not overlap (LINE_PITCH >= 16). Rows in the gap between lines are misses.

Test Plan:
- Reset: assert rst mid-line with de_in=1 -> rgb_out, all addresses and syncs are 0 at once. After release, the first valid pixel appears 2 cycles after the first input.
- Pass-through: val=0/0/0, rgb_in=24'h123456, pixel (100,100) -> rgb_out=24'h123456 two cycles later, with hsync_out/vsync_out equal to the inputs delayed 2.
- Glyph hit: shown R=4, ROM returns row 16'b0000001111111000, vcnt=Y0, hcnt=X0+32+6 -> addr_R_u=0 and rgb_out=FG_COLOR. hcnt=X0+32+5 -> rgb_in.
- Leading-zero blanking: R=7, ROM returns all ones -> hundreds and tens slots pass rgb_in, the units slot shows FG_COLOR. R=100 -> all three slots are drawn.
- Frame-synchronous update: strobe val_r=255 mid-frame -> the display is unchanged until the vsync_in rising edge, then changes. A strobe on the update cycle is shown one frame later.
- Line selection: vcnt=Y0+LINE_PITCH+3 -> addr_G_h/d/u=3, R and B addresses are 0, and only G-line pixels can be set. vcnt=Y0+17 -> miss, pass-through.

Source files
------------

// File: rtl/rgb_value_overlay.sv
// Overlays the probed pixel's R, G and B values as three lines of three 16x16
// decimal glyphs on a video stream, with a fixed two-cycle pipeline.
module rgb_value_overlay #(
    parameter int          X0         = 16,
    parameter int          Y0         = 16,
    parameter int          LINE_PITCH = 20,
    parameter logic [23:0] FG_COLOR   = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcnt,
    input  logic [10:0] vcnt,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [23:0] rgb_in,
    input  logic [7:0]  val_r,
    input  logic [7:0]  val_g,
    input  logic [7:0]  val_b,
    input  logic        val_valid,
    output logic [3:0]  addr_R_h,
    output logic [3:0]  addr_R_d,
    output logic [3:0]  addr_R_u,
    output logic [3:0]  addr_G_h,
    output logic [3:0]  addr_G_d,
    output logic [3:0]  addr_G_u,
    output logic [3:0]  addr_B_h,
    output logic [3:0]  addr_B_d,
    output logic [3:0]  addr_B_u,
    input  logic [0:15] Char_R_h,
    input  logic [0:15] Char_R_d,
    input  logic [0:15] Char_R_u,
    input  logic [0:15] Char_G_h,
    input  logic [0:15] Char_G_d,
    input  logic [0:15] Char_G_u,
    input  logic [0:15] Char_B_h,
    input  logic [0:15] Char_B_d,
    input  logic [0:15] Char_B_u,
    output logic [23:0] rgb_out,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out
);

    logic       vs_prev;
    logic [7:0] pend_r, pend_g, pend_b;
    logic [7:0] shown_r, shown_g, shown_b;

    // Values change only at the frame boundary so a digit never tears mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev <= 1'b0;
            pend_r  <= 8'd0;
            pend_g  <= 8'd0;
            pend_b  <= 8'd0;
            shown_r <= 8'd0;
            shown_g <= 8'd0;
            shown_b <= 8'd0;
        end else begin
            vs_prev <= vsync_in;
            if (vsync_in && !vs_prev) begin
                shown_r <= pend_r;
                shown_g <= pend_g;
                shown_b <= pend_b;
            end
            if (val_valid) begin
                pend_r <= val_r;
                pend_g <= val_g;
                pend_b <= val_b;
            end
        end
    end

    logic [2:0] blank_h, blank_d;
    assign blank_h = {shown_b < 8'd100, shown_g < 8'd100, shown_r < 8'd100};
    assign blank_d = {shown_b < 8'd10,  shown_g < 8'd10,  shown_r < 8'd10};

    logic [10:0] dy [3];
    logic [10:0] dx [3];
    logic [2:0]  line_hit, slot_hit;
    logic [1:0]  line_idx, slot_idx;
    logic        line_any, slot_any;
    logic [3:0]  col;
    logic        blank_sel;

    // Lines never overlap, so at most one line and one slot can hit.
    always_comb begin
        line_idx = 2'd0;
        slot_idx = 2'd0;
        col      = 4'd0;
        for (int k = 0; k < 3; k++) begin
            dy[k]       = vcnt - 11'(Y0 + k * LINE_PITCH);
            dx[k]       = hcnt - 11'(X0 + k * 16);
            line_hit[k] = (vcnt >= 11'(Y0 + k * LINE_PITCH)) && (dy[k] < 11'd16);
            slot_hit[k] = (hcnt >= 11'(X0 + k * 16)) && (dx[k] < 11'd16);
            if (line_hit[k]) line_idx = 2'(k);
            if (slot_hit[k]) begin
                slot_idx = 2'(k);
                col      = dx[k][3:0];
            end
        end
        line_any  = |line_hit;
        slot_any  = |slot_hit;
        blank_sel = 1'b0;
        if (slot_idx == 2'd0)      blank_sel = blank_h[line_idx];
        else if (slot_idx == 2'd1) blank_sel = blank_d[line_idx];
    end

    logic        s1_line_hit, s1_slot_hit, s1_blank;
    logic [1:0]  s1_line, s1_slot;
    logic [3:0]  s1_col;
    logic [23:0] s1_rgb;
    logic        s1_de, s1_hs, s1_vs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_line_hit <= 1'b0;
            s1_slot_hit <= 1'b0;
            s1_blank    <= 1'b0;
            s1_line     <= 2'd0;
            s1_slot     <= 2'd0;
            s1_col      <= 4'd0;
            s1_rgb      <= 24'd0;
            s1_de       <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            addr_R_h    <= 4'd0;
            addr_R_d    <= 4'd0;
            addr_R_u    <= 4'd0;
            addr_G_h    <= 4'd0;
            addr_G_d    <= 4'd0;
            addr_G_u    <= 4'd0;
            addr_B_h    <= 4'd0;
            addr_B_d    <= 4'd0;
            addr_B_u    <= 4'd0;
        end else begin
            s1_line_hit <= line_any;
            s1_slot_hit <= slot_any;
            s1_blank    <= blank_sel;
            s1_line     <= line_idx;
            s1_slot     <= slot_idx;
            s1_col      <= col;
            s1_rgb      <= rgb_in;
            s1_de       <= de_in;
            s1_hs       <= hsync_in;
            s1_vs       <= vsync_in;
            addr_R_h    <= line_hit[0] ? dy[0][3:0] : 4'd0;
            addr_R_d    <= line_hit[0] ? dy[0][3:0] : 4'd0;
            addr_R_u    <= line_hit[0] ? dy[0][3:0] : 4'd0;
            addr_G_h    <= line_hit[1] ? dy[1][3:0] : 4'd0;
            addr_G_d    <= line_hit[1] ? dy[1][3:0] : 4'd0;
            addr_G_u    <= line_hit[1] ? dy[1][3:0] : 4'd0;
            addr_B_h    <= line_hit[2] ? dy[2][3:0] : 4'd0;
            addr_B_d    <= line_hit[2] ? dy[2][3:0] : 4'd0;
            addr_B_u    <= line_hit[2] ? dy[2][3:0] : 4'd0;
        end
    end

    // ROM rows arrive combinationally from the stage-1 addresses.
    logic glyph_bit;
    always_comb begin
        glyph_bit = 1'b0;
        case ({s1_line, s1_slot})
            4'b00_00: glyph_bit = Char_R_h[s1_col];
            4'b00_01: glyph_bit = Char_R_d[s1_col];
            4'b00_10: glyph_bit = Char_R_u[s1_col];
            4'b01_00: glyph_bit = Char_G_h[s1_col];
            4'b01_01: glyph_bit = Char_G_d[s1_col];
            4'b01_10: glyph_bit = Char_G_u[s1_col];
            4'b10_00: glyph_bit = Char_B_h[s1_col];
            4'b10_01: glyph_bit = Char_B_d[s1_col];
            4'b10_10: glyph_bit = Char_B_u[s1_col];
            default:  glyph_bit = 1'b0;
        endcase
    end

    logic pix_on;
    assign pix_on = s1_line_hit && s1_slot_hit && !s1_blank && glyph_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_out   <= 24'd0;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rgb_out   <= !s1_de ? 24'd0 : (pix_on ? FG_COLOR : s1_rgb);
            de_out    <= s1_de;
            hsync_out <= s1_hs;
            vsync_out <= s1_vs;
        end
    end

endmodule

// File: tb/tb_rgb_value_overlay.sv
// Scoreboard bench for rgb_value_overlay: a driver pushes reference-model
// expectations per cycle, a negedge monitor pops and compares.
module tb_rgb_value_overlay;

    localparam int          X0 = 16;
    localparam int          Y0 = 16;
    localparam int          LP = 20;
    localparam logic [23:0] FG = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcnt = '0, vcnt = '0;
    logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [23:0] rgb_in = '0;
    logic [7:0]  val_r = '0, val_g = '0, val_b = '0;
    logic        val_valid = 1'b0;
    logic [3:0]  addr_R_h, addr_R_d, addr_R_u, addr_G_h, addr_G_d, addr_G_u;
    logic [3:0]  addr_B_h, addr_B_d, addr_B_u;
    logic [15:0] ch [9];
    logic [23:0] rgb_out;
    logic        de_out, hsync_out, vsync_out;

    // Glyph ROMs: pat[line*3+slot][row], leftmost pixel is the MSB.
    logic [15:0] pat [9][16];
    assign ch[0] = pat[0][addr_R_h];
    assign ch[1] = pat[1][addr_R_d];
    assign ch[2] = pat[2][addr_R_u];
    assign ch[3] = pat[3][addr_G_h];
    assign ch[4] = pat[4][addr_G_d];
    assign ch[5] = pat[5][addr_G_u];
    assign ch[6] = pat[6][addr_B_h];
    assign ch[7] = pat[7][addr_B_d];
    assign ch[8] = pat[8][addr_B_u];

    rgb_value_overlay #(.X0(X0), .Y0(Y0), .LINE_PITCH(LP), .FG_COLOR(FG)) dut (
        .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .val_r(val_r), .val_g(val_g), .val_b(val_b), .val_valid(val_valid),
        .addr_R_h(addr_R_h), .addr_R_d(addr_R_d), .addr_R_u(addr_R_u),
        .addr_G_h(addr_G_h), .addr_G_d(addr_G_d), .addr_G_u(addr_G_u),
        .addr_B_h(addr_B_h), .addr_B_d(addr_B_d), .addr_B_u(addr_B_u),
        .Char_R_h(ch[0]), .Char_R_d(ch[1]), .Char_R_u(ch[2]),
        .Char_G_h(ch[3]), .Char_G_d(ch[4]), .Char_G_u(ch[5]),
        .Char_B_h(ch[6]), .Char_B_d(ch[7]), .Char_B_u(ch[8]),
        .rgb_out(rgb_out), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [26:0] exp_q[$];
    logic [35:0] addr_q[$];

    // Reference model state
    int m_shown [3];
    int m_pend [3];
    bit m_prev_vs;

    function automatic logic [26:0] model_pix(int h, int v, bit d, logic [23:0] rgb, bit hs, bit vs);
        logic [23:0] c;
        c = d ? rgb : 24'd0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                int yb, xb, row, cl;
                bit blank;
                yb = Y0 + k * LP;
                xb = X0 + 16 * j;
                if (d && v >= yb && v < yb + 16 && h >= xb && h < xb + 16) begin
                    row   = v - yb;
                    cl    = h - xb;
                    blank = (j == 0 && m_shown[k] < 100) || (j == 1 && m_shown[k] < 10);
                    if (!blank && pat[3 * k + j][row][15 - cl]) c = FG;
                end
            end
        end
        return {c, d, hs, vs};
    endfunction

    function automatic logic [35:0] model_addr(int v);
        logic [35:0] a;
        a = '0;
        for (int k = 0; k < 3; k++) begin
            int yb;
            logic [3:0] r;
            yb = Y0 + k * LP;
            r  = (v >= yb && v < yb + 16) ? 4'(v - yb) : 4'd0;
            a[35 - 12 * k -: 12] = {r, r, r};
        end
        return a;
    endfunction

    task automatic drive(input int h, input int v, input bit d, input logic [23:0] rgb,
                         input bit hs, input bit vs, input bit vv,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        hcnt = 11'(h); vcnt = 11'(v); de_in = d; rgb_in = rgb;
        hsync_in = hs; vsync_in = vs; val_valid = vv;
        val_r = r; val_g = g; val_b = b;
        exp_q.push_back(model_pix(h, v, d, rgb, hs, vs));
        addr_q.push_back(model_addr(v));
        if (vs && !m_prev_vs) m_shown = m_pend;
        if (vv) begin
            m_pend[0] = int'(r); m_pend[1] = int'(g); m_pend[2] = int'(b);
        end
        m_prev_vs = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int h, input int v, input logic [23:0] rgb);
        drive(h, v, 1'b1, rgb, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic strobe(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        drive(0, 0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b1, r, g, b);
    endtask

    task automatic frame_edge();
        drive(0, 0, 1'b0, 24'd0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        idle(1);
    endtask

    // Pipeline drained of active pixels before the ROM contents change.
    task automatic set_pat_all(input logic [15:0] p);
        idle(2);
        for (int s = 0; s < 9; s++) for (int r = 0; r < 16; r++) pat[s][r] = p;
    endtask

    task automatic set_pat_rand();
        idle(2);
        for (int s = 0; s < 9; s++) for (int r = 0; r < 16; r++) pat[s][r] = 16'($urandom);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {28'd0, rgb_out, de_out, hsync_out, vsync_out,
                     addr_R_h, addr_R_d, addr_R_u, addr_G_h, addr_G_d, addr_G_u,
                     addr_B_h, addr_B_d, addr_B_u}, 64'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        addr_q.delete();
        m_shown = '{0, 0, 0};
        m_pend  = '{0, 0, 0};
        m_prev_vs = 1'b0;
    endtask

    // Release then prefill with the two reset-valued outputs still in flight.
    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(27'd0);
        exp_q.push_back(27'd0);
        addr_q.push_back(36'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0) begin
                logic [26:0] e;
                e = exp_q.pop_front();
                checks++;
                if ({rgb_out, de_out, hsync_out, vsync_out} !== e) begin
                    errors++;
                    $display("FAIL pixel: got rgb=%h de/hs/vs=%b want rgb=%h de/hs/vs=%b",
                             rgb_out, {de_out, hsync_out, vsync_out}, e[26:3], e[2:0]);
                end
            end
            if (addr_q.size() > 0) begin
                logic [35:0] a;
                a = addr_q.pop_front();
                checks++;
                if ({addr_R_h, addr_R_d, addr_R_u, addr_G_h, addr_G_d, addr_G_u,
                     addr_B_h, addr_B_d, addr_B_u} !== a) begin
                    errors++;
                    $display("FAIL addr: got %h want %h",
                             {addr_R_h, addr_R_d, addr_R_u, addr_G_h, addr_G_d, addr_G_u,
                              addr_B_h, addr_B_d, addr_B_u}, a);
                end
            end
        end
    end

    initial begin
        for (int s = 0; s < 9; s++) for (int r = 0; r < 16; r++) pat[s][r] = 16'd0;
        model_reset();
        #12;
        check_all_zero("reset_state");
        release_rst();

        // Pass-through with syncs
        px(100, 100, 24'h123456);
        drive(100, 100, 1'b1, 24'h123456, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(101, 100, 1'b1, 24'h654321, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        idle(2);

        // Glyph hit on R units digit
        strobe(8'd4, 8'd0, 8'd0);
        frame_edge();
        set_pat_all(16'b0000001111111000);
        px(X0 + 38, Y0, 24'h0a0b0c);
        px(X0 + 37, Y0, 24'h0a0b0c);
        px(X0 + 44, Y0 + 5, 24'h0a0b0c);
        px(X0 + 45, Y0 + 15, 24'h0a0b0c);

        // Leading-zero blanking
        strobe(8'd7, 8'd7, 8'd7);
        frame_edge();
        set_pat_all(16'hFFFF);
        for (int h = X0 - 2; h < X0 + 50; h += 3) px(h, Y0 + 2, 24'h202020);
        strobe(8'd100, 8'd10, 8'd99);
        frame_edge();
        for (int k = 0; k < 3; k++)
            for (int h = X0 - 1; h <= X0 + 48; h += 7) px(h, Y0 + k * LP + 4, 24'h303030);

        // Frame-synchronous update, including a strobe on the update cycle
        px(X0 + 5, Y0 + 1, 24'h111111);
        strobe(8'd255, 8'd0, 8'd0);
        px(X0 + 5, Y0 + 1, 24'h111111);
        drive(0, 0, 1'b0, 24'd0, 1'b0, 1'b1, 1'b1, 8'd9, 8'd0, 8'd0);
        idle(1);
        px(X0 + 5, Y0 + 1, 24'h111111);
        px(X0 + 20, Y0 + 1, 24'h111111);
        frame_edge();
        px(X0 + 5, Y0 + 1, 24'h111111);
        px(X0 + 20, Y0 + 1, 24'h111111);
        px(X0 + 36, Y0 + 1, 24'h111111);

        // Line selection and the inter-line gap
        strobe(8'd123, 8'd234, 8'd56);
        frame_edge();
        set_pat_rand();
        for (int h = X0; h < X0 + 48; h += 5) px(h, Y0 + LP + 3, 24'h445566);
        for (int h = X0; h < X0 + 48; h += 5) px(h, Y0 + 17, 24'h445566);
        px(X0 + 47, Y0 + 2 * LP + 15, 24'h778899);
        px(X0 + 48, Y0 + 2 * LP + 15, 24'h778899);
        px(X0 - 1, Y0 + 2 * LP + 16, 24'h778899);

        // Randomized traffic with random ROM contents, values and frame edges
        for (int blk = 0; blk < 6; blk++) begin
            set_pat_rand();
            for (int i = 0; i < 150; i++) begin
                int sel;
                logic [7:0] rv [3];
                for (int k = 0; k < 3; k++) begin
                    sel = $urandom_range(0, 2);
                    rv[k] = (sel == 0) ? 8'($urandom_range(0, 9)) :
                            (sel == 1) ? 8'($urandom_range(10, 99)) : 8'($urandom_range(100, 255));
                end
                drive($urandom_range(0, X0 + 56), $urandom_range(0, Y0 + 2 * LP + 20),
                      $urandom_range(0, 3) != 0, 24'($urandom),
                      1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0,
                      $urandom_range(0, 9) == 0, rv[0], rv[1], rv[2]);
            end
        end

        // Reset mid-line with active video
        strobe(8'd200, 8'd200, 8'd200);
        frame_edge();
        set_pat_all(16'hFFFF);
        px(X0 + 3, Y0 + 3, 24'habcdef);
        px(X0 + 4, Y0 + 3, 24'habcdef);
        rst = 1'b1;
        model_reset();
        #1;
        check_all_zero("mid_line_reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        release_rst();
        px(X0 + 3, Y0 + 3, 24'h5a5a5a);
        px(200, 200, 24'h010203);
        px(X0 + 3, Y0 + LP + 3, 24'h040506);
        idle(2);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0 || addr_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size() + addr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
